// File: rtl/mac_neuron_unit_if.sv
// Handshake bundle between the weight/activation sequencer (master) and the
// neuron MAC unit (slave). Result side feeds the layer output buffer.
interface mac_neuron_unit_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
);
  // control
  logic                     start;
  logic signed [ACC_W-1:0]  bias;
  logic                     forget;
  // operand stream
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] weight;
  logic signed [DATA_W-1:0] in;
  // result
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out;
  // status
  logic                     busy;
  logic                     overflow;

  modport master (
    output start, bias, forget, in_valid, weight, in, out_ready,
    input  in_ready, out_valid, out, busy, overflow
  );

  modport slave (
    input  start, bias, forget, in_valid, weight, in, out_ready,
    output in_ready, out_valid, out, busy, overflow
  );
endinterface

// File: rtl/mac_neuron_unit.sv
// Single-neuron MAC: out = sat((bias + sum w_i*x_i) >>> FRAC_SHIFT), optional
// ReLU, over N_INPUTS streamed pairs. Operands are registered before the
// multiply, so the accumulator trails the last accept by one edge (DRAIN).
module mac_neuron_unit #(
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 24,
  parameter int N_INPUTS   = 4,
  parameter int FRAC_SHIFT = 2,
  parameter bit RELU_EN    = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  mac_neuron_unit_if.slave io
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(N_INPUTS + 1);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] OUT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, FINISH, OUT} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] w_q, w_d;
  logic signed [DATA_W-1:0] x_q, x_d;
  logic                     p_valid_q, p_valid_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [DATA_W-1:0] out_q, out_d;
  logic                     out_valid_q, out_valid_d;
  logic                     ovf_q, ovf_d;

  // ---------------- datapath ----------------
  logic signed [PROD_W-1:0] prod;
  logic        [ACC_W:0]    sum_w;
  logic                     add_ovf;
  logic signed [ACC_W-1:0]  acc_add_sat;
  logic signed [ACC_W-1:0]  shr;
  logic signed [ACC_W-1:0]  relu_r;
  logic                     out_hi, out_lo;
  logic signed [DATA_W-1:0] out_sat;
  logic                     accept;

  // Full-width signed product of the registered operands.
  assign prod = w_q * x_q;

  // One guard bit: overflow shows as disagreement between the top two bits.
  assign sum_w = {acc_q[ACC_W-1], acc_q}
               + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
  assign add_ovf     = sum_w[ACC_W] ^ sum_w[ACC_W-1];
  assign acc_add_sat = add_ovf ? (sum_w[ACC_W] ? ACC_MIN : ACC_MAX)
                               : sum_w[ACC_W-1:0];

  // Scale, optional ReLU (never flags overflow), then clamp to output range.
  assign shr     = acc_q >>> FRAC_SHIFT;
  assign relu_r  = (RELU_EN && (shr < 0)) ? '0 : shr;
  assign out_hi  = relu_r > OUT_MAX;
  assign out_lo  = relu_r < OUT_MIN;
  assign out_sat = out_hi ? OUT_MAX[DATA_W-1:0]
                 : out_lo ? OUT_MIN[DATA_W-1:0]
                 : relu_r[DATA_W-1:0];

  assign accept = io.in_valid && (state_q == ACCUM);

  // Next-state and datapath update; forget overrides everything at the end.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    w_d         = w_q;
    x_d         = x_q;
    p_valid_d   = 1'b0;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;

    // A product latched on the previous edge is folded in on this one.
    if (p_valid_q) begin
      acc_d = acc_add_sat;
      if (add_ovf) ovf_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (io.start) begin
          acc_d   = io.bias;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          w_d       = io.weight;
          x_d       = io.in;
          p_valid_d = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(N_INPUTS - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = FINISH;
      end
      FINISH: begin
        out_d       = out_sat;
        out_valid_d = 1'b1;
        if (out_hi || out_lo) ovf_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (io.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort: drop the evaluation but keep the last result and sticky flag.
    if (io.forget) begin
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      p_valid_d   = 1'b0;
      out_valid_d = 1'b0;
      ovf_d       = ovf_q;
    end
  end

  // State and datapath registers, async active-high clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      w_q         <= '0;
      x_q         <= '0;
      p_valid_q   <= 1'b0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      w_q         <= w_d;
      x_q         <= x_d;
      p_valid_q   <= p_valid_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  // Status decoded from state so reset clears them without waiting an edge.
  assign io.in_ready  = (state_q == ACCUM);
  assign io.busy      = (state_q != IDLE);
  assign io.out       = out_q;
  assign io.out_valid = out_valid_q;
  assign io.overflow  = ovf_q;

endmodule

// File: tb/tb_mac_neuron_unit.sv
// Bench for mac_neuron_unit: three builds (default, RELU_EN=0, ACC_W=16)
// share one stimulus stream; a reference model fills per-build scoreboards.
module tb_mac_neuron_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic               start, forget, in_valid, out_ready;
  logic signed [23:0] bias;
  logic signed [7:0]  weight, xin;

  mac_neuron_unit_if #(.DATA_W(8), .ACC_W(24)) if0 ();
  mac_neuron_unit_if #(.DATA_W(8), .ACC_W(24)) if1 ();
  mac_neuron_unit_if #(.DATA_W(8), .ACC_W(16)) if2 ();

  assign if0.start = start;  assign if1.start = start;  assign if2.start = start;
  assign if0.bias  = bias;   assign if1.bias  = bias;   assign if2.bias  = bias[15:0];
  assign if0.forget = forget; assign if1.forget = forget; assign if2.forget = forget;
  assign if0.in_valid = in_valid; assign if1.in_valid = in_valid; assign if2.in_valid = in_valid;
  assign if0.weight = weight; assign if1.weight = weight; assign if2.weight = weight;
  assign if0.in = xin;       assign if1.in = xin;       assign if2.in = xin;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready; assign if2.out_ready = out_ready;

  mac_neuron_unit #(.DATA_W(8), .ACC_W(24), .N_INPUTS(4), .FRAC_SHIFT(2), .RELU_EN(1'b1))
    u0 (.clk(clk), .reset(reset), .io(if0));
  mac_neuron_unit #(.DATA_W(8), .ACC_W(24), .N_INPUTS(4), .FRAC_SHIFT(2), .RELU_EN(1'b0))
    u1 (.clk(clk), .reset(reset), .io(if1));
  mac_neuron_unit #(.DATA_W(8), .ACC_W(16), .N_INPUTS(4), .FRAC_SHIFT(2), .RELU_EN(1'b1))
    u2 (.clk(clk), .reset(reset), .io(if2));

  logic [2:0] valid_a, busy_a, rdy_a, ov_a;
  logic [7:0] out_a [3];
  assign valid_a = {if2.out_valid, if1.out_valid, if0.out_valid};
  assign busy_a  = {if2.busy, if1.busy, if0.busy};
  assign rdy_a   = {if2.in_ready, if1.in_ready, if0.in_ready};
  assign ov_a    = {if2.overflow, if1.overflow, if0.overflow};
  assign out_a[0] = if0.out;
  assign out_a[1] = if1.out;
  assign out_a[2] = if2.out;

  typedef struct { logic [7:0] o; bit ov; } exp_t;
  exp_t sb [3][$];

  int checks = 0;
  int errors = 0;

  // Reference: exact integer arithmetic with explicit clamps.
  function automatic void model(input int bias_v, input int wv[4], input int xv[4],
                                input int accw, input bit relu,
                                output logic [7:0] o, output bit ov);
    longint acc, mx, mn, r;
    mx  = (longint'(1) <<< (accw - 1)) - 1;
    mn  = -mx - 1;
    acc = bias_v;
    ov  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      acc = acc + longint'(wv[i]) * longint'(xv[i]);
      if (acc > mx) begin acc = mx; ov = 1'b1; end
      else if (acc < mn) begin acc = mn; ov = 1'b1; end
    end
    r = acc >>> 2;
    if (relu && r < 0) r = 0;
    if (r > 127) begin r = 127; ov = 1'b1; end
    else if (r < -128) begin r = -128; ov = 1'b1; end
    o = r[7:0];
  endfunction

  // Full evaluation through all three builds with scoreboard checking.
  task automatic run_neuron(input string tag, input int bias_v, input int wv[4],
                            input int xv[4], input bit toggle, input int hold);
    int i, cyc, n;
    bit take;
    exp_t e, e0;
    @(posedge clk); #1;
    start = 1'b1;
    bias  = bias_v;
    for (int k = 0; k < 3; k++) begin
      model(bias_v, wv, xv, (k == 2) ? 16 : 24, (k != 1), e.o, e.ov);
      sb[k].push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy_a !== 3'b111 || ov_a !== 3'b000) begin
      errors++;
      $display("FAIL %s start: busy=%b ov=%b, want busy=111 ov=000", tag, busy_a, ov_a);
    end
    i = 0; cyc = 0;
    while (i < 4 && cyc < 60) begin
      in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      weight   = wv[i][7:0];
      xin      = xv[i][7:0];
      take     = in_valid && rdy_a[0];
      @(posedge clk); #1;
      if (take) i++;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (i !== 4) begin
      errors++;
      $display("FAIL %s feed_timeout: accepted=%0d, want 4", tag, i);
    end
    checks++;
    if (rdy_a !== 3'b000) begin
      errors++;
      $display("FAIL %s drain_ready: in_ready=%b, want 000", tag, rdy_a);
    end
    n = 0;
    while (valid_a[0] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 2 || valid_a !== 3'b111) begin
      errors++;
      $display("FAIL %s latency: edges=%0d valid=%b, want 2 / 111", tag, n, valid_a);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (sb[k].size() == 0) begin
        errors++;
        $display("FAIL %s sb_empty dut%0d", tag, k);
      end else begin
        e = sb[k].pop_front();
        if (k == 0) e0 = e;
        if (out_a[k] !== e.o || ov_a[k] !== e.ov) begin
          errors++;
          $display("FAIL %s result dut%0d: out=%0d ov=%b, want out=%0d ov=%b",
                   tag, k, $signed(out_a[k]), ov_a[k], $signed(e.o), e.ov);
        end
      end
    end
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checks++;
      if (valid_a !== 3'b111 || out_a[0] !== e0.o || rdy_a !== 3'b000) begin
        errors++;
        $display("FAIL %s hold%0d: valid=%b out=%0d rdy=%b, want 111 %0d 000",
                 tag, h, valid_a, $signed(out_a[0]), rdy_a, $signed(e0.o));
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (valid_a !== 3'b000 || busy_a !== 3'b000 || out_a[0] !== e0.o) begin
      errors++;
      $display("FAIL %s handshake: valid=%b busy=%b out=%0d, want 000 000 %0d",
               tag, valid_a, busy_a, $signed(out_a[0]), $signed(e0.o));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (valid_a !== 3'b000 || busy_a !== 3'b000 || rdy_a !== 3'b000 ||
        ov_a !== 3'b000 || out_a[0] !== 8'd0) begin
      errors++;
      $display("FAIL reset: valid=%b busy=%b rdy=%b ov=%b out=%0d, want all 0",
               valid_a, busy_a, rdy_a, ov_a, out_a[0]);
    end
    #20 reset = 1'b0;
  endtask

  task automatic test_basic();
    run_neuron("basic", 0, '{2, 4, -1, 1}, '{3, 5, 6, 1}, 1'b0, 0);
  endtask

  task automatic test_negative_relu();
    run_neuron("neg_relu", 0, '{-3, -3, -3, -3}, '{10, 10, 10, 10}, 1'b0, 0);
  endtask

  task automatic test_saturation();
    run_neuron("sat", 0, '{127, 127, 127, 127}, '{127, 127, 127, 127}, 1'b0, 0);
    // the following start must clear the sticky flag (checked at start)
    run_neuron("after_sat", 4, '{1, 1, 1, 1}, '{1, 1, 1, 1}, 1'b0, 0);
  endtask

  task automatic test_handshake();
    run_neuron("handshake", 8, '{1, 1, 1, 1}, '{1, 1, 1, 1}, 1'b1, 5);
  endtask

  task automatic test_forget();
    int acc_n;
    @(posedge clk); #1;
    start = 1'b1; bias = 24'sd1000;
    @(posedge clk); #1;
    start = 1'b0;
    acc_n = 0;
    in_valid = 1'b1; weight = 8'sd50; xin = 8'sd50;
    repeat (2) begin
      if (rdy_a[0]) acc_n++;
      @(posedge clk); #1;
    end
    forget = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    forget = 1'b0; start = 1'b0; in_valid = 1'b0;
    checks++;
    if (acc_n !== 2 || busy_a !== 3'b000 || rdy_a !== 3'b000 || valid_a !== 3'b000) begin
      errors++;
      $display("FAIL forget: accepts=%0d busy=%b rdy=%b valid=%b, want 2 000 000 000",
               acc_n, busy_a, rdy_a, valid_a);
    end
    @(posedge clk); #1;
    checks++;
    if (busy_a !== 3'b000) begin
      errors++;
      $display("FAIL forget_idle: busy=%b, want 000", busy_a);
    end
    run_neuron("post_forget", 0, '{1, 1, 1, 1}, '{4, 4, 4, 4}, 1'b0, 0);
  endtask

  task automatic test_random();
    int wv[4], xv[4], b;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) begin
        wv[i] = int'($urandom_range(0, 255)) - 128;
        xv[i] = int'($urandom_range(0, 255)) - 128;
      end
      b = int'($urandom_range(0, 4000)) - 2000;
      run_neuron("random", b, wv, xv, r[0], r);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    start = 1'b1; bias = '0;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; weight = 8'sd3; xin = 8'sd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (valid_a !== 3'b000 || rdy_a !== 3'b000 || busy_a !== 3'b000 || ov_a !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: valid=%b rdy=%b busy=%b ov=%b, want all 000",
               valid_a, rdy_a, busy_a, ov_a);
    end
    #1 reset = 1'b0;
    run_neuron("post_reset", 0, '{2, 4, -1, 1}, '{3, 5, 6, 1}, 1'b0, 0);
  endtask

  initial begin
    start = 1'b0; forget = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    bias = '0; weight = '0; xin = '0;
    test_reset();
    test_basic();
    test_negative_relu();
    test_saturation();
    test_handshake();
    test_forget();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
